// File: rtl/spike_frame_driver.sv
// Spike frame driver: buffers upstream frames, issues them one at a time to a LIF neuron,
// waits for its result under a timeout and hands the spike plus a fired-frame count downstream.
module spike_frame_driver #(
    parameter int S_WIDTH        = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 7,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_WIDTH-1:0]   frame_in,
    input  logic                 frame_in_valid,
    output logic                 frame_in_ready,
    output logic                 nrn_start,
    output logic [S_WIDTH-1:0]   nrn_spikes,
    input  logic                 nrn_spike_out,
    input  logic                 nrn_valid,
    output logic                 res_valid,
    output logic                 res_spike,
    output logic [CNT_WIDTH-1:0] res_count,
    input  logic                 res_ready,
    output logic                 timeout_err,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    localparam logic [FIFO_AW:0]   FULL_OCC     = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [TO_WIDTH-1:0] TIMEOUT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    logic [S_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     occ_q, occ_d;
    logic                 push, pop;

    state_t               state_q;
    logic [TO_WIDTH-1:0]  timer_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 nrn_start_q;
    logic [S_WIDTH-1:0]   nrn_spikes_q;
    logic                 res_valid_q;
    logic                 res_spike_q;
    logic                 err_q;

    // Ready comes from registered occupancy, so a pop on a full FIFO cannot admit a push the same cycle.
    assign frame_in_ready = (occ_q != FULL_OCC);
    assign push           = frame_in_valid && frame_in_ready;
    assign pop            = (state_q == ISSUE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Frame storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= frame_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            nrn_start_q  <= 1'b0;
            nrn_spikes_q <= '0;
            res_valid_q  <= 1'b0;
            res_spike_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            nrn_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (occ_q != '0) begin
                        state_q      <= ISSUE;
                        nrn_start_q  <= 1'b1;
                        nrn_spikes_q <= mem_q[rd_ptr_q];
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A result on the last allowed cycle still beats the timeout.
                    if (nrn_valid) begin
                        res_spike_q <= nrn_spike_out;
                        if (nrn_spike_out && (cnt_q != CNT_MAX)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        res_spike_q <= 1'b0;
                        err_q       <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign nrn_start   = nrn_start_q;
    assign nrn_spikes  = nrn_spikes_q;
    assign res_valid   = res_valid_q;
    assign res_spike   = res_spike_q;
    assign res_count   = cnt_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != IDLE) || (occ_q != '0);

endmodule

// File: tb/tb_spike_frame_driver.sv
// Self-checking bench for spike_frame_driver: a transaction-level model predicts every output each
// cycle while directed scenarios and a randomized phase drive frames, neuron responses and back-pressure.
module tb_spike_frame_driver;

    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] frame_in;
    logic          frame_in_valid;
    logic          frame_in_ready;
    logic          nrn_start;
    logic [SW-1:0] nrn_spikes;
    logic          nrn_spike_out;
    logic          nrn_valid;
    logic          res_valid;
    logic          res_spike;
    logic [CW-1:0] res_count;
    logic          res_ready;
    logic          timeout_err;
    logic          busy;

    spike_frame_driver dut (
        .clk           (clk),
        .rst           (rst),
        .frame_in      (frame_in),
        .frame_in_valid(frame_in_valid),
        .frame_in_ready(frame_in_ready),
        .nrn_start     (nrn_start),
        .nrn_spikes    (nrn_spikes),
        .nrn_spike_out (nrn_spike_out),
        .nrn_valid     (nrn_valid),
        .res_valid     (res_valid),
        .res_spike     (res_spike),
        .res_count     (res_count),
        .res_ready     (res_ready),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef enum int {P_IDLE, P_ISSUE, P_WAIT, P_REPORT} phase_t;

    logic [SW-1:0] mQ[$];
    phase_t        mPhase;
    int            mWaitCycles;
    logic [SW-1:0] mSpikes;
    logic          mResSpike;
    int            mCount;
    logic          mErr;

    int   curDelay;
    logic curSpike;
    int   planMode;
    int   planDelay;
    logic planSpike;
    int   spurEn;

    int   assertCount = 0;
    int   failCount   = 0;
    int   cycNum      = 0;
    int   lastPushCycle;
    int   startCycle;
    logic [SW-1:0] startSpikes;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycNum, act, exp);
        end
    endtask

    function automatic void modelReset();
        mQ.delete();
        mPhase      = P_IDLE;
        mWaitCycles = 0;
        mSpikes     = '0;
        mResSpike   = 1'b0;
        mCount      = 0;
        mErr        = 1'b0;
    endfunction

    // Plan mode 0: fixed delay/spike; 2: random quick results; 3: random including timeouts and the boundary.
    function automatic void choosePlan();
        int r;
        if (planMode == 0) begin
            curDelay = planDelay;
            curSpike = planSpike;
        end else begin
            r = (planMode == 3) ? int'($urandom_range(0, 9)) : 5;
            if (r == 0)      curDelay = 0;
            else if (r == 1) curDelay = TMO;
            else             curDelay = int'($urandom_range(1, 12));
            curSpike = 1'($urandom_range(0, 1));
        end
    endfunction

    function automatic void modelStep();
        logic doPush;
        doPush = frame_in_valid && (mQ.size() < DEPTH);
        if (rst) begin
            modelReset();
            return;
        end
        case (mPhase)
            P_IDLE: begin
                if (mQ.size() > 0) begin
                    mPhase  = P_ISSUE;
                    mSpikes = mQ[0];
                end
            end
            P_ISSUE: begin
                void'(mQ.pop_front());
                mWaitCycles = 0;
                mPhase      = P_WAIT;
                choosePlan();
            end
            P_WAIT: begin
                mWaitCycles++;
                if (nrn_valid) begin
                    mResSpike = nrn_spike_out;
                    if (nrn_spike_out && mCount < 65535) mCount++;
                    mPhase = P_REPORT;
                end else if (mWaitCycles == TMO) begin
                    mResSpike = 1'b0;
                    mErr      = 1'b1;
                    mPhase    = P_REPORT;
                end
            end
            P_REPORT: begin
                if (res_ready) mPhase = P_IDLE;
            end
            default: mPhase = P_IDLE;
        endcase
        if (doPush) mQ.push_back(frame_in);
    endfunction

    function automatic void driveNeuron();
        nrn_valid     = 1'b0;
        nrn_spike_out = 1'($urandom_range(0, 1));
        if (mPhase == P_WAIT) begin
            if (curDelay != 0 && mWaitCycles + 1 == curDelay) begin
                nrn_valid     = 1'b1;
                nrn_spike_out = curSpike;
            end
        end else if (spurEn != 0 && $urandom_range(0, 3) == 0) begin
            nrn_valid = 1'b1;
        end
    endfunction

    task automatic checkOutput();
        checkEq("ready", {31'd0, frame_in_ready}, {31'd0, mQ.size() < DEPTH});
        checkEq("busy", {31'd0, busy}, {31'd0, (mPhase != P_IDLE) || (mQ.size() > 0)});
        checkEq("start", {31'd0, nrn_start}, {31'd0, mPhase == P_ISSUE});
        checkEq("spikes", {24'd0, nrn_spikes}, {24'd0, mSpikes});
        checkEq("resValid", {31'd0, res_valid}, {31'd0, mPhase == P_REPORT});
        checkEq("timeoutErr", {31'd0, timeout_err}, {31'd0, mErr});
        if (mPhase == P_REPORT) begin
            checkEq("resSpike", {31'd0, res_spike}, {31'd0, mResSpike});
            checkEq("resCount", {16'd0, res_count}, 32'(mCount));
        end
    endtask

    // One clock of the bench: inputs are already driven at the falling edge when this is called.
    task automatic applyStimulus();
        driveNeuron();
        checkOutput();
        if (!rst && frame_in_valid && mQ.size() < DEPTH) lastPushCycle = cycNum;
        if (nrn_start === 1'b1) begin
            startCycle  = cycNum;
            startSpikes = nrn_spikes;
        end
        modelStep();
        @(posedge clk);
        @(negedge clk);
        cycNum++;
    endtask

    task automatic pushFrame(input logic [SW-1:0] f);
        frame_in       = f;
        frame_in_valid = 1'b1;
        applyStimulus();
        frame_in_valid = 1'b0;
    endtask

    task automatic runUntilReport(input string name, input int maxCycles);
        int n = 0;
        while (mPhase != P_REPORT && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        assertCount++;
        if (mPhase != P_REPORT) begin
            failCount++;
            $display("[TB] FAIL %s: no result within %0d cycles, required one", name, maxCycles);
        end
    endtask

    task automatic runUntilIdle(input string name, input int maxCycles);
        int n = 0;
        while (!(mPhase == P_IDLE && mQ.size() == 0) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        assertCount++;
        if (!(mPhase == P_IDLE && mQ.size() == 0)) begin
            failCount++;
            $display("[TB] FAIL %s: not drained within %0d cycles, required idle", name, maxCycles);
        end
    endtask

    initial begin
        logic [SW-1:0] bpFrames[4];
        int firstStart;
        int countBefore;
        int n;
        bpFrames = '{8'h1A, 8'h11, 8'h02, 8'h57};
        rst = 1'b1; frame_in = '0; frame_in_valid = 1'b0; res_ready = 1'b0;
        nrn_valid = 1'b0; nrn_spike_out = 1'b0;
        spurEn = 0; planMode = 0; planDelay = 10; planSpike = 1'b1;
        curDelay = 0; curSpike = 1'b0; lastPushCycle = 0; startCycle = 0; startSpikes = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkEq("resetReady", {31'd0, frame_in_ready}, 32'd1);
        checkEq("resetStart", {31'd0, nrn_start}, 32'd0);
        checkEq("resetResValid", {31'd0, res_valid}, 32'd0);
        checkEq("resetBusy", {31'd0, busy}, 32'd0);
        checkEq("resetErr", {31'd0, timeout_err}, 32'd0);

        spurEn = 1;
        pushFrame(8'hFB);
        runUntilReport("firstResult", 50);
        checkEq("startLatency", 32'(startCycle - lastPushCycle), 32'd2);
        checkEq("startFrame", {24'd0, startSpikes}, 32'hFB);
        checkEq("firstSpike", {31'd0, res_spike}, 32'd1);
        checkEq("firstCount", {16'd0, res_count}, 32'd1);
        firstStart = startCycle;

        planMode = 2;
        for (int i = 0; i < 4; i++) pushFrame(bpFrames[i]);
        checkEq("fullAfterFour", {31'd0, frame_in_ready}, 32'd0);
        applyStimulus();
        checkEq("heldValid", {31'd0, res_valid}, 32'd1);
        checkEq("heldCount", {16'd0, res_count}, 32'd1);
        checkEq("noStartDuringHold", 32'(startCycle), 32'(firstStart));

        res_ready = 1'b1;
        frame_in = 8'hC3;
        frame_in_valid = 1'b1;
        n = 0;
        while (mPhase != P_ISSUE && n < 10) begin
            applyStimulus();
            n++;
        end
        checkEq("fullIssueReady", {31'd0, frame_in_ready}, 32'd0);
        checkEq("issueFrameOrder", {24'd0, nrn_spikes}, 32'h1A);
        applyStimulus();
        checkEq("slotFreedReady", {31'd0, frame_in_ready}, 32'd1);
        applyStimulus();
        frame_in_valid = 1'b0;
        checkEq("refilledReady", {31'd0, frame_in_ready}, 32'd0);
        runUntilIdle("drainBackPressure", 1000);

        planMode = 0; planDelay = TMO; planSpike = 1'b1; res_ready = 1'b0;
        pushFrame(8'h3C);
        runUntilReport("boundaryResult", 100);
        checkEq("boundaryWait", 32'(cycNum - startCycle), 32'd65);
        checkEq("boundarySpike", {31'd0, res_spike}, 32'd1);
        checkEq("boundaryErr", {31'd0, timeout_err}, 32'd0);
        res_ready = 1'b1;
        runUntilIdle("drainBoundary", 20);

        planDelay = 0; res_ready = 1'b0; countBefore = mCount;
        pushFrame(8'h77);
        runUntilReport("timeoutResult", 100);
        checkEq("timeoutWait", 32'(cycNum - startCycle), 32'd65);
        checkEq("timeoutSpike", {31'd0, res_spike}, 32'd0);
        checkEq("timeoutCount", {16'd0, res_count}, 32'(countBefore));
        checkEq("timeoutErrSet", {31'd0, timeout_err}, 32'd1);
        res_ready = 1'b1;
        planDelay = 5; planSpike = 1'b1;
        pushFrame(8'h0F);
        runUntilReport("afterTimeoutResult", 50);
        checkEq("errSticky", {31'd0, timeout_err}, 32'd1);
        checkEq("afterTimeoutSpike", {31'd0, res_spike}, 32'd1);
        runUntilIdle("drainTimeout", 20);

        planDelay = 0;
        pushFrame(8'hA1);
        pushFrame(8'hA2);
        pushFrame(8'hA3);
        n = 0;
        while (!(mPhase == P_WAIT && mWaitCycles >= 10) && n < 40) begin
            applyStimulus();
            n++;
        end
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkEq("rstReady", {31'd0, frame_in_ready}, 32'd1);
        checkEq("rstBusy", {31'd0, busy}, 32'd0);
        checkEq("rstResValid", {31'd0, res_valid}, 32'd0);
        checkEq("rstErr", {31'd0, timeout_err}, 32'd0);
        planDelay = 3; planSpike = 1'b1;
        pushFrame(8'h55);
        runUntilReport("rstResult", 20);
        checkEq("rstCount", {16'd0, res_count}, 32'd1);
        runUntilIdle("drainRst", 20);

        planMode = 3;
        for (int c = 0; c < 3000; c++) begin
            frame_in_valid = 1'($urandom_range(0, 1));
            frame_in       = 8'($urandom);
            res_ready      = ($urandom_range(0, 9) < 7);
            rst            = ($urandom_range(0, 499) == 0);
            applyStimulus();
        end
        rst = 1'b0; frame_in_valid = 1'b0; res_ready = 1'b1;
        runUntilIdle("drainRandom", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/spike_frame_driver.md
Name: spike_frame_driver

Overview:
- Transmit-side companion to the LIF neuron top level.
- Accepts input spike frames from an upstream producer through a valid/ready stream and buffers them in a small FIFO.
- Issues each frame to the neuron as a one-cycle start pulse with the frame held stable, then waits for the neuron's valid, with a timeout.
- Returns the neuron's output spike and a running fired-frame count to a downstream consumer through a valid/ready result port.

Parameters:
- S_WIDTH, 8, spike frame width (one bit per synapse).
- FIFO_DEPTH, 4, number of buffered frames; power of two.
- FIFO_AW, 2, log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before a frame is declared lost.
- TO_WIDTH, 7, timer width; must hold TIMEOUT_CYCLES.
- CNT_WIDTH, 16, width of the fired-frame counter.

Ports:
- clk  in  1  system clock; the block's single clock domain.
- rst  in  1  reset; synchronous, active-high.
- frame_in  in  S_WIDTH  upstream spike frame.
- frame_in_valid  in  1  upstream frame valid.
- frame_in_ready  out  1  FIFO not full.
- nrn_start  out  1  one-cycle start pulse to the neuron.
- nrn_spikes  out  S_WIDTH  frame presented to the neuron.
- nrn_spike_out  in  1  neuron output spike.
- nrn_valid  in  1  neuron result valid.
- res_valid  out  1  result available.
- res_spike  out  1  spike result for the current frame.
- res_count  out  CNT_WIDTH  running count of frames that fired.
- res_ready  in  1  downstream accepts the result.
- timeout_err  out  1  sticky flag: some frame timed out.
- busy  out  1  high whenever the state is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (synchronous, on a clk edge with rst=1):
  - FIFO empty; state IDLE; timer 0; fired count 0.
  - All outputs 0 except frame_in_ready=1.
  - Applies from any state, including mid-WAIT or mid-REPORT. The in-flight frame and the FIFO contents are discarded.
- FIFO:
  - Push when frame_in_valid && frame_in_ready.
  - Pop on the ISSUE cycle.
  - Push and pop in the same cycle are legal, including when full: the pop frees a slot, but frame_in_ready is still 0 that cycle, so no push occurs.
  - frame_in_ready = !full, taken from registered occupancy.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, REPORT.
  - IDLE: if the FIFO is non-empty, go to ISSUE next cycle.
  - ISSUE (exactly 1 cycle):
    - nrn_start=1.
    - nrn_spikes is registered from the FIFO head and held stable until the next ISSUE.
    - Pop the FIFO; clear the timer; go to WAIT.
    - nrn_valid in this cycle is ignored.
  - WAIT:
    - nrn_start=0.
    - If nrn_valid: capture res_spike=nrn_spike_out. If the spike is 1, increment the count (saturating at 2^CNT_WIDTH-1). Go to REPORT.
    - Else if timer==TIMEOUT_CYCLES-1: res_spike=0, set timeout_err, count unchanged, go to REPORT.
    - Else timer+1.
    - If nrn_valid arrives on the final timeout cycle, valid wins and no error is flagged.
  - REPORT:
    - res_valid=1; res_spike and res_count are held stable while res_valid && !res_ready.
    - On res_ready, go to IDLE next cycle with res_valid=0.
- Latency: if a frame handshakes in cycle N into an empty FIFO with the FSM in IDLE, nrn_start=1 in cycle N+2.
- Throughput: at most one frame outstanding at the neuron. Minimum spacing between start pulses is 4 cycles (ISSUE, WAIT, REPORT, IDLE), plus neuron latency.
- res_count is valid only while res_valid=1. It includes the current frame.
- timeout_err is cleared only by rst.
- nrn_valid outside WAIT is ignored and has no side effects.

Test Plan:
- Reset then idle:
  - Check frame_in_ready=1, nrn_start=0, res_valid=0, busy=0, timeout_err=0.
  - Push 8'b11111011 in cycle N → nrn_start high for exactly cycle N+2 with nrn_spikes=8'hFB.
  - Model returns nrn_valid=1, spike=1 after 10 cycles → res_valid=1, res_spike=1, res_count=1.
- Back-pressure:
  - Hold res_ready=0 for 5 cycles during REPORT → res_* stable throughout, no new nrn_start.
  - Meanwhile push 4 frames (8'h1A, 8'h11, 8'h02, 8'h57) → frame_in_ready=0 after the 4th.
  - Release res_ready → frames issued in push order; res_count increments only on frames that spiked.
- FIFO full with simultaneous pop:
  - FIFO full, FSM in ISSUE, frame_in_valid=1 → no push that cycle.
  - Next cycle ready=1 and the push is accepted; occupancy returns to 4.
- Timeout:
  - Model never asserts nrn_valid → exactly 64 WAIT cycles, then res_valid=1, res_spike=0, count unchanged, timeout_err=1.
  - Stays 1 through later successful frames.
- Boundary valid:
  - nrn_valid on WAIT cycle 64 → res_spike captured, timeout_err remains 0.
  - Spurious nrn_valid in IDLE/ISSUE → no effect.
- Reset mid-WAIT with 2 frames queued:
  - Next cycle: FIFO empty, state IDLE, res_valid=0, res_count restarts from 0 on the next result, timeout_err=0.
